// File: rtl/ball_engine.sv
`default_nettype none
// ============================================================================
// Module : ball_engine
// Brief  : Pong ball engine: tick-enabled motion, wall/paddle bounces,
//          scoring and serve sequencing.
// Rev    : 1.0  initial release
// ============================================================================
module ball_engine #(
    parameter int SCREEN_W    = 640,
    parameter int SCREEN_H    = 480,
    parameter int BALL_W      = 32,
    parameter int STEP_X      = 2,
    parameter int STEP_Y      = 1,
    parameter int TICK_DIV    = 1000000,
    parameter int PADDLE_W    = 8,
    parameter int PADDLE_H    = 64,
    parameter int PADDLE_XL   = 16,
    parameter int PADDLE_XR   = 616,
    parameter int SERVE_DELAY = 50,
    parameter int MAX_SCORE   = 9
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       serve,
    input  logic [8:0] paddle_l_y,
    input  logic [8:0] paddle_r_y,
    output logic [9:0] ball_x,
    output logic [8:0] ball_y,
    output logic       tick,
    output logic       hit,
    output logic       point_l,
    output logic       point_r,
    output logic [3:0] score_l,
    output logic [3:0] score_r,
    output logic       game_over
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int CD_W  = (SERVE_DELAY > 1) ? $clog2(SERVE_DELAY + 1) : 1;

    localparam logic [CNT_W-1:0] C_TICK_LAST  = CNT_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] C_CNT_ONE    = CNT_W'(1);
    localparam logic [CD_W-1:0]  C_SERVE_CNT  = CD_W'(SERVE_DELAY);
    localparam logic [CD_W-1:0]  C_CD_ONE     = CD_W'(1);
    localparam logic [9:0]       C_CENTRE_X   = 10'((SCREEN_W - BALL_W) / 2);
    localparam logic [8:0]       C_CENTRE_Y   = 9'((SCREEN_H - BALL_W) / 2);
    localparam logic [9:0]       C_STEP_X     = 10'(STEP_X);
    localparam logic [8:0]       C_STEP_Y     = 9'(STEP_Y);
    localparam logic [9:0]       C_LEFT_STOP  = 10'(PADDLE_XL + PADDLE_W);
    localparam logic [9:0]       C_RIGHT_STOP = 10'(PADDLE_XR - BALL_W);
    localparam logic [8:0]       C_FLOOR_Y    = 9'(SCREEN_H - BALL_W);
    localparam logic [3:0]       C_MAX        = 4'(MAX_SCORE);

    // 11-bit operands so sums like y+BALL_W+STEP never wrap
    localparam logic [10:0] C11_BALL   = 11'(BALL_W);
    localparam logic [10:0] C11_STEP_X = 11'(STEP_X);
    localparam logic [10:0] C11_STEP_Y = 11'(STEP_Y);
    localparam logic [10:0] C11_SCR_W  = 11'(SCREEN_W);
    localparam logic [10:0] C11_SCR_H  = 11'(SCREEN_H);
    localparam logic [10:0] C11_FACE_L = 11'(PADDLE_XL + PADDLE_W);
    localparam logic [10:0] C11_FACE_R = 11'(PADDLE_XR);
    localparam logic [10:0] C11_PAD_H  = 11'(PADDLE_H);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_SERVE_WAIT = 3'd1,
        S_PLAY       = 3'd2,
        S_POINT      = 3'd3,
        S_GAME_OVER  = 3'd4
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CD_W-1:0]  r_cd;
    logic [9:0]       r_x;
    logic [8:0]       r_y;
    logic             r_dx_right;
    logic             r_dy_down;
    logic             r_left_scored;
    logic [3:0]       r_score_l;
    logic [3:0]       r_score_r;
    logic             r_hit;
    logic             r_point_l;
    logic             r_point_r;
    logic             r_game_over;

    logic        w_tick;
    logic [10:0] w_x;
    logic [10:0] w_y;
    logic [10:0] w_pl;
    logic [10:0] w_pr;
    logic        w_ovl_l;
    logic        w_ovl_r;
    logic        w_hit_l;
    logic        w_hit_r;
    logic        w_miss_l;
    logic        w_miss_r;
    logic [8:0]  w_y_next;
    logic        w_dy_next;
    logic [9:0]  w_x_move;
    logic [3:0]  w_score_l_inc;
    logic [3:0]  w_score_r_inc;

    assign w_tick = (r_cnt == C_TICK_LAST);
    assign w_x    = {1'b0, r_x};
    assign w_y    = {2'b00, r_y};
    assign w_pl   = {2'b00, paddle_l_y};
    assign w_pr   = {2'b00, paddle_r_y};

    assign w_ovl_l  = (w_y + C11_BALL > w_pl) && (w_y < w_pl + C11_PAD_H);
    assign w_ovl_r  = (w_y + C11_BALL > w_pr) && (w_y < w_pr + C11_PAD_H);
    assign w_hit_l  = !r_dx_right && (w_x >= C11_FACE_L)
                      && (w_x < C11_FACE_L + C11_STEP_X) && w_ovl_l;
    assign w_hit_r  = r_dx_right && (w_x + C11_BALL <= C11_FACE_R)
                      && (w_x + C11_BALL + C11_STEP_X > C11_FACE_R) && w_ovl_r;
    assign w_miss_l = !r_dx_right && (w_x < C11_STEP_X);
    assign w_miss_r = r_dx_right && (w_x + C11_BALL + C11_STEP_X > C11_SCR_W);

    assign w_x_move = r_dx_right ? r_x + C_STEP_X : r_x - C_STEP_X;

    assign w_score_l_inc = (r_score_l >= C_MAX) ? C_MAX : r_score_l + 4'd1;
    assign w_score_r_inc = (r_score_r >= C_MAX) ? C_MAX : r_score_r + 4'd1;

    always_comb begin
        w_y_next  = r_y;
        w_dy_next = r_dy_down;
        if (r_dy_down) begin
            if (w_y + C11_BALL + C11_STEP_Y >= C11_SCR_H) begin
                w_y_next  = C_FLOOR_Y;
                w_dy_next = 1'b0;
            end else begin
                w_y_next = r_y + C_STEP_Y;
            end
        end else if (w_y <= C11_STEP_Y) begin
            w_y_next  = '0;
            w_dy_next = 1'b1;
        end else begin
            w_y_next = r_y - C_STEP_Y;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_cd          <= '0;
            r_x           <= C_CENTRE_X;
            r_y           <= C_CENTRE_Y;
            r_dx_right    <= 1'b1;
            r_dy_down     <= 1'b1;
            r_left_scored <= 1'b0;
            r_score_l     <= '0;
            r_score_r     <= '0;
            r_hit         <= 1'b0;
            r_point_l     <= 1'b0;
            r_point_r     <= 1'b0;
            r_game_over   <= 1'b0;
        end else begin
            r_cnt     <= w_tick ? '0 : r_cnt + C_CNT_ONE;
            r_hit     <= 1'b0;
            r_point_l <= 1'b0;
            r_point_r <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (serve) begin
                        r_cd    <= C_SERVE_CNT;
                        r_state <= S_SERVE_WAIT;
                    end
                end
                S_SERVE_WAIT: begin
                    if (w_tick) begin
                        if (r_cd <= C_CD_ONE) begin
                            r_cd    <= '0;
                            r_state <= S_PLAY;
                        end else begin
                            r_cd <= r_cd - C_CD_ONE;
                        end
                    end
                end
                S_PLAY: begin
                    if (w_tick) begin
                        r_y       <= w_y_next;
                        r_dy_down <= w_dy_next;
                        // A paddle hit wins over a miss detected on the same tick
                        if (w_hit_l) begin
                            r_x        <= C_LEFT_STOP;
                            r_dx_right <= 1'b1;
                            r_hit      <= 1'b1;
                        end else if (w_hit_r) begin
                            r_x        <= C_RIGHT_STOP;
                            r_dx_right <= 1'b0;
                            r_hit      <= 1'b1;
                        end else if (w_miss_l) begin
                            r_left_scored <= 1'b0;
                            r_state       <= S_POINT;
                        end else if (w_miss_r) begin
                            r_left_scored <= 1'b1;
                            r_state       <= S_POINT;
                        end else begin
                            r_x <= w_x_move;
                        end
                    end
                end
                S_POINT: begin
                    r_x        <= C_CENTRE_X;
                    r_y        <= C_CENTRE_Y;
                    r_cd       <= C_SERVE_CNT;
                    // Next serve heads toward the player who conceded
                    r_dx_right <= r_left_scored;
                    if (r_left_scored) begin
                        r_point_l <= 1'b1;
                        r_score_l <= w_score_l_inc;
                    end else begin
                        r_point_r <= 1'b1;
                        r_score_r <= w_score_r_inc;
                    end
                    if ((r_left_scored ? w_score_l_inc : w_score_r_inc) == C_MAX) begin
                        r_game_over <= 1'b1;
                        r_state     <= S_GAME_OVER;
                    end else begin
                        r_state <= S_SERVE_WAIT;
                    end
                end
                S_GAME_OVER: begin
                    if (serve) begin
                        r_score_l   <= '0;
                        r_score_r   <= '0;
                        r_dx_right  <= 1'b1;
                        r_cd        <= C_SERVE_CNT;
                        r_game_over <= 1'b0;
                        r_state     <= S_SERVE_WAIT;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign ball_x    = r_x;
    assign ball_y    = r_y;
    assign tick      = w_tick;
    assign hit       = r_hit;
    assign point_l   = r_point_l;
    assign point_r   = r_point_r;
    assign score_l   = r_score_l;
    assign score_r   = r_score_r;
    assign game_over = r_game_over;

endmodule
`default_nettype wire

// File: tb/tb_ball_engine.sv
`default_nettype none
// ============================================================================
// Module : tb_ball_engine
// Brief  : Randomised scoreboard bench for ball_engine against a game model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_ball_engine;

    localparam int TD  = 4;
    localparam int SD  = 3;
    localparam int MS  = 3;
    localparam int SW  = 640;
    localparam int SH  = 480;
    localparam int BW  = 32;
    localparam int SX  = 2;
    localparam int SY  = 1;
    localparam int PW  = 8;
    localparam int PH  = 64;
    localparam int PXL = 16;
    localparam int PXR = 616;
    localparam int CX  = (SW - BW) / 2;
    localparam int CY  = (SH - BW) / 2;
    localparam int N_CYCLES = 60000;

    localparam int M_IDLE = 0;
    localparam int M_WAIT = 1;
    localparam int M_PLAY = 2;
    localparam int M_POINT = 3;
    localparam int M_OVER = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       serve = 1'b0;
    logic [8:0] paddle_l_y = 9'd200;
    logic [8:0] paddle_r_y = 9'd200;
    logic [9:0] ball_x;
    logic [8:0] ball_y;
    logic       tick;
    logic       hit;
    logic       point_l;
    logic       point_r;
    logic [3:0] score_l;
    logic [3:0] score_r;
    logic       game_over;

    ball_engine #(
        .SCREEN_W(SW), .SCREEN_H(SH), .BALL_W(BW), .STEP_X(SX), .STEP_Y(SY),
        .TICK_DIV(TD), .PADDLE_W(PW), .PADDLE_H(PH), .PADDLE_XL(PXL),
        .PADDLE_XR(PXR), .SERVE_DELAY(SD), .MAX_SCORE(MS)
    ) dut (
        .clk(clk), .reset(reset), .serve(serve),
        .paddle_l_y(paddle_l_y), .paddle_r_y(paddle_r_y),
        .ball_x(ball_x), .ball_y(ball_y), .tick(tick), .hit(hit),
        .point_l(point_l), .point_r(point_r),
        .score_l(score_l), .score_r(score_r), .game_over(game_over)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cyc;
        int x, y, sl, sr, go, tk, hit, pl, pr;
    } obs_t;

    obs_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    bit   mon_en = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    // Game model: plain integer geometry, signed directions
    int m_cnt, m_mode, m_cd, m_x, m_y, m_dx, m_dy, m_sl, m_sr;
    int m_hit, m_pl, m_pr, m_go;
    bit m_left_scored;

    task automatic model_reset();
        m_cnt = 0; m_mode = M_IDLE; m_cd = 0;
        m_x = CX; m_y = CY; m_dx = 1; m_dy = 1;
        m_sl = 0; m_sr = 0; m_hit = 0; m_pl = 0; m_pr = 0; m_go = 0;
        m_left_scored = 1'b0;
    endtask

    function automatic bit overlaps(input int by, input int py);
        return (by + BW > py) && (by < py + PH);
    endfunction

    task automatic model_step(input bit sv, input int ply, input int pry);
        bit tk;
        int nx, ny, sc;
        tk = (m_cnt == TD - 1);
        m_cnt = tk ? 0 : m_cnt + 1;
        m_hit = 0; m_pl = 0; m_pr = 0;
        case (m_mode)
            M_IDLE: if (sv) begin m_mode = M_WAIT; m_cd = SD; end
            M_WAIT: if (tk) begin
                m_cd = m_cd - 1;
                if (m_cd <= 0) m_mode = M_PLAY;
            end
            M_PLAY: if (tk) begin
                ny = m_y + m_dy * SY;
                nx = m_x + m_dx * SX;
                if (ny <= 0) begin ny = 0; m_dy = 1; end
                else if (ny + BW >= SH) begin ny = SH - BW; m_dy = -1; end
                if (m_dx < 0 && m_x >= PXL + PW && nx < PXL + PW && overlaps(m_y, ply)) begin
                    m_x = PXL + PW; m_dx = 1; m_hit = 1;
                end else if (m_dx > 0 && m_x + BW <= PXR && nx + BW > PXR && overlaps(m_y, pry)) begin
                    m_x = PXR - BW; m_dx = -1; m_hit = 1;
                end else if (nx < 0) begin
                    m_left_scored = 1'b0; m_mode = M_POINT;
                end else if (nx + BW > SW) begin
                    m_left_scored = 1'b1; m_mode = M_POINT;
                end else begin
                    m_x = nx;
                end
                m_y = ny;
            end
            M_POINT: begin
                if (m_left_scored) begin
                    m_sl = (m_sl + 1 > MS) ? MS : m_sl + 1; m_pl = 1; sc = m_sl; m_dx = 1;
                end else begin
                    m_sr = (m_sr + 1 > MS) ? MS : m_sr + 1; m_pr = 1; sc = m_sr; m_dx = -1;
                end
                m_x = CX; m_y = CY;
                if (sc == MS) m_mode = M_OVER;
                else begin m_mode = M_WAIT; m_cd = SD; end
            end
            M_OVER: if (sv) begin
                m_sl = 0; m_sr = 0; m_dx = 1; m_cd = SD; m_mode = M_WAIT;
            end
            default: m_mode = M_IDLE;
        endcase
        m_go = (m_mode == M_OVER) ? 1 : 0;
    endtask

    function automatic int clamp_y(input int v);
        if (v < 0) return 0;
        if (v > 511) return 511;
        return v;
    endfunction

    // Picks inputs for the coming edge, advances the model and queues any visible event
    task automatic cycle_step();
        obs_t e;
        serve = ($urandom_range(0, 63) == 0);
        if ($urandom_range(0, 7) == 0) begin
            if ($urandom_range(0, 1) == 0) paddle_l_y = 9'(clamp_y(m_y + int'($urandom_range(0, 90)) - 60));
            else paddle_l_y = 9'($urandom_range(0, 511));
            if ($urandom_range(0, 1) == 0) paddle_r_y = 9'(clamp_y(m_y + int'($urandom_range(0, 90)) - 60));
            else paddle_r_y = 9'($urandom_range(0, 511));
        end
        model_step(serve, int'(paddle_l_y), int'(paddle_r_y));
        e.cyc = cyc + 1;
        e.x = m_x; e.y = m_y; e.sl = m_sl; e.sr = m_sr; e.go = m_go;
        e.tk = (m_cnt == TD - 1) ? 1 : 0;
        e.hit = m_hit; e.pl = m_pl; e.pr = m_pr;
        if (e.tk != 0 || e.hit != 0 || e.pl != 0 || e.pr != 0) q.push_back(e);
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ball_x"}, int'(ball_x), CX);
        chk({tag, "_ball_y"}, int'(ball_y), CY);
        chk({tag, "_score_l"}, int'(score_l), 0);
        chk({tag, "_score_r"}, int'(score_r), 0);
        chk({tag, "_game_over"}, int'(game_over), 0);
        chk({tag, "_tick"}, int'(tick), 0);
        chk({tag, "_hit"}, int'(hit), 0);
        chk({tag, "_point_l"}, int'(point_l), 0);
        chk({tag, "_point_r"}, int'(point_r), 0);
    endtask

    // Monitor: every tick or pulse the DUT shows must match the next queued expectation
    initial begin
        obs_t a, e;
        forever begin
            @(negedge clk);
            if (mon_en && (tick || hit || point_l || point_r)) begin
                a.cyc = cyc; a.x = int'(ball_x); a.y = int'(ball_y);
                a.sl = int'(score_l); a.sr = int'(score_r); a.go = int'(game_over);
                a.tk = int'(tick); a.hit = int'(hit); a.pl = int'(point_l); a.pr = int'(point_r);
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_event cyc=%0d x=%0d y=%0d tick=%0d hit=%0d pl=%0d pr=%0d",
                             a.cyc, a.x, a.y, a.tk, a.hit, a.pl, a.pr);
                end else begin
                    e = q.pop_front();
                    if (a != e) begin
                        errors++;
                        $display("FAIL obs got cyc=%0d x=%0d y=%0d sl=%0d sr=%0d go=%0d t=%0d h=%0d pl=%0d pr=%0d expected cyc=%0d x=%0d y=%0d sl=%0d sr=%0d go=%0d t=%0d h=%0d pl=%0d pr=%0d",
                                 a.cyc, a.x, a.y, a.sl, a.sr, a.go, a.tk, a.hit, a.pl, a.pr,
                                 e.cyc, e.x, e.y, e.sl, e.sr, e.go, e.tk, e.hit, e.pl, e.pr);
                    end
                end
            end
        end
    end

    initial begin
        bit rst_done;
        rst_done = 1'b0;
        model_reset();
        #1 reset = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        #2 reset = 1'b1;
        cycle_step();
        for (int n = 0; n < N_CYCLES; n++) begin
            @(negedge clk);
            if (!rst_done && n > 20000 && m_mode == M_PLAY && m_x > 400 && m_cnt == 2) begin
                rst_done = 1'b1;
                #2 reset = 1'b0;
                #1 check_reset_outputs("midplay_reset");
                model_reset();
                repeat (2) @(negedge clk);
                #2 reset = 1'b1;
            end
            cycle_step();
        end
        @(negedge clk);
        #1 mon_en = 1'b0;
        chk("pending_expectations", q.size(), 0);
        chk("midplay_reset_reached", int'(rst_done), 1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
